pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 40 ++++
 rtl/pipe_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the pipeline controller.
// The master modport drives stage requests; the slave modport is the controller itself.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        mispredict_i;
  logic [31:0] branch_tar_addr_real_i;
  logic        excp_i;
  logic [3:0]  excp_cause_i;
  logic        mret_i;
  logic [31:0] mepc_i;
  logic        irq_i;
  logic        irq_en_i;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic [31:0] mtvec_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        trap_we;
  logic [31:0] trap_epc;
  logic [31:0] trap_cause;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem,
    output mispredict_i, branch_tar_addr_real_i,
    output excp_i, excp_cause_i, mret_i, mepc_i,
    output irq_i, irq_en_i, mem_valid_i, mem_pc_i, mtvec_i,
    input  stall, flush, new_pc, trap_we, trap_epc, trap_cause
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem,
    input  mispredict_i, branch_tar_addr_real_i,
    input  excp_i, excp_cause_i, mret_i, mepc_i,
    input  irq_i, irq_en_i, mem_valid_i, mem_pc_i, mtvec_i,
    output stall, flush, new_pc, trap_we, trap_epc, trap_cause
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/trap controller: per-stage stall ladder, prioritised flush events,
// interrupt pending tracking and a MEM-stall watchdog that raises a timeout trap.
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h3000_0000,
  parameter int          STALL_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  localparam int CNT_W = (STALL_TIMEOUT > 255) ? $clog2(STALL_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_HOLD     = 2'd1,
    S_IRQ_PEND = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_irq_meta;
  logic             r_irq_s;
  logic [CNT_W-1:0] r_cnt;

  logic             w_hold;
  logic             w_irq_want;
  logic             w_take;
  logic             w_timeout;
  logic             w_ev_excp;
  logic             w_ev_mret;
  logic             w_ev_misp;
  logic             w_flush;
  logic [5:0]       w_stall;
  logic [31:0]      w_new_pc;
  logic             w_trap_we;
  logic [31:0]      w_trap_epc;
  logic [31:0]      w_trap_cause;

  // In HOLD the ID/EX requests come from squashed bubbles, so only MEM-side events count.
  always_comb begin
    w_hold     = (r_state == S_HOLD);
    w_irq_want = r_irq_s & bus.irq_en_i;
    w_take     = !w_hold & w_irq_want & bus.mem_valid_i & !bus.stallreq_mem;
    w_timeout  = bus.stallreq_mem & (r_cnt >= CNT_LAST);
    w_ev_excp  = bus.excp_i & bus.mem_valid_i;
    w_ev_mret  = bus.mret_i & bus.mem_valid_i;
    w_ev_misp  = bus.mispredict_i & !w_hold;
  end

  // Flush priority resolution and stall ladder; reset overrides everything.
  always_comb begin
    w_flush      = 1'b0;
    w_stall      = 6'b000000;
    w_new_pc     = 32'h0000_0000;
    w_trap_we    = 1'b0;
    w_trap_epc   = 32'h0000_0000;
    w_trap_cause = 32'h0000_0000;
    if (!rst) begin
      w_new_pc = RESET_PC;
    end else if (w_ev_excp) begin
      w_flush      = 1'b1;
      w_new_pc     = bus.mtvec_i;
      w_trap_we    = 1'b1;
      w_trap_epc   = bus.mem_pc_i;
      w_trap_cause = {28'h000_0000, bus.excp_cause_i};
    end else if (w_timeout) begin
      w_flush      = 1'b1;
      w_new_pc     = bus.mtvec_i;
      w_trap_we    = 1'b1;
      w_trap_epc   = bus.mem_pc_i;
      w_trap_cause = 32'd5;
    end else if (w_ev_mret) begin
      w_flush  = 1'b1;
      w_new_pc = bus.mepc_i;
    end else if (w_take) begin
      w_flush      = 1'b1;
      w_new_pc     = bus.mtvec_i;
      w_trap_we    = 1'b1;
      w_trap_epc   = bus.mem_pc_i;
      w_trap_cause = 32'h8000_000B;
    end else if (w_ev_misp) begin
      w_flush  = 1'b1;
      w_new_pc = bus.branch_tar_addr_real_i;
    end else if (bus.stallreq_mem) begin
      w_stall = 6'b011111;
    end else if (bus.stallreq_ex && !w_hold) begin
      w_stall = 6'b001111;
    end else if (bus.stallreq_id && !w_hold) begin
      w_stall = 6'b000111;
    end else begin
      w_stall = 6'b000000;
    end
  end

  // Next-state logic; an irq that loses to another event is simply re-evaluated after HOLD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_flush) begin
          w_state_nxt = S_HOLD;
        end else if (w_irq_want) begin
          w_state_nxt = S_IRQ_PEND;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_HOLD: begin
        w_state_nxt = S_RUN;
      end
      S_IRQ_PEND: begin
        if (w_flush) begin
          w_state_nxt = S_HOLD;
        end else if (!w_irq_want) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IRQ_PEND;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Two-flop synchronizer for the external interrupt level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_meta <= 1'b0;
      r_irq_s    <= 1'b0;
    end else begin
      r_irq_meta <= bus.irq_i;
      r_irq_s    <= r_irq_meta;
    end
  end

  // Consecutive MEM-stall counter, saturating so a stuck request never wraps back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_flush || !bus.stallreq_mem) begin
      r_cnt <= '0;
    end else if (r_cnt >= CNT_SAT) begin
      r_cnt <= r_cnt;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.stall      = w_stall;
  assign bus.flush      = w_flush;
  assign bus.new_pc     = w_new_pc;
  assign bus.trap_we    = w_trap_we;
  assign bus.trap_epc   = w_trap_epc;
  assign bus.trap_cause = w_trap_cause;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall ladder, flush priorities, interrupt pending,
// stall timeout and asynchronous reset, with hand-computed expectations.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pipe_ctrl_if bus_if ();

  pipe_ctrl #(
    .RESET_PC      (32'h3000_0000),
    .STALL_TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.stallreq_id            = 1'b0;
    bus_if.stallreq_ex            = 1'b0;
    bus_if.stallreq_mem           = 1'b0;
    bus_if.mispredict_i           = 1'b0;
    bus_if.branch_tar_addr_real_i = 32'h0000_0000;
    bus_if.excp_i                 = 1'b0;
    bus_if.excp_cause_i           = 4'd0;
    bus_if.mret_i                 = 1'b0;
    bus_if.mepc_i                 = 32'h3000_0200;
    bus_if.irq_i                  = 1'b0;
    bus_if.irq_en_i               = 1'b0;
    bus_if.mem_valid_i            = 1'b0;
    bus_if.mem_pc_i               = 32'h3000_0010;
    bus_if.mtvec_i                = 32'h3000_0100;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    clear_inputs();
    bus_if.stallreq_id = 1'b1;
    #2;
    check_eq("rst_stall", 32'(bus_if.stall), 32'h0);
    check_eq("rst_flush", 32'(bus_if.flush), 32'h0);
    check_eq("rst_new_pc", bus_if.new_pc, 32'h3000_0000);
    check_eq("rst_trap_we", 32'(bus_if.trap_we), 32'h0);
    check_eq("rst_epc", bus_if.trap_epc, 32'h0);
    check_eq("rst_cause", bus_if.trap_cause, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus_if.stallreq_id = 1'b0;
    tick();

    // stall ladder
    bus_if.stallreq_id = 1'b1;
    #1 check_eq("ladder_id", 32'(bus_if.stall), 32'h07);
    bus_if.stallreq_ex = 1'b1;
    #1 check_eq("ladder_ex", 32'(bus_if.stall), 32'h0F);
    bus_if.stallreq_mem = 1'b1;
    #1 check_eq("ladder_mem", 32'(bus_if.stall), 32'h1F);
    check_eq("ladder_noflush", 32'(bus_if.flush), 32'h0);
    clear_inputs();
    #1 check_eq("ladder_clear", 32'(bus_if.stall), 32'h0);
    tick();

    // mispredict, then a mispredict in HOLD is ignored
    bus_if.mispredict_i = 1'b1;
    bus_if.branch_tar_addr_real_i = 32'h3000_0040;
    bus_if.stallreq_id = 1'b1;
    #1;
    check_eq("misp_flush", 32'(bus_if.flush), 32'h1);
    check_eq("misp_pc", bus_if.new_pc, 32'h3000_0040);
    check_eq("misp_trap_we", 32'(bus_if.trap_we), 32'h0);
    check_eq("misp_stall", 32'(bus_if.stall), 32'h0);
    tick();
    bus_if.branch_tar_addr_real_i = 32'h3000_0080;
    #1;
    check_eq("hold_misp_flush", 32'(bus_if.flush), 32'h0);
    check_eq("hold_id_stall", 32'(bus_if.stall), 32'h0);
    tick();
    clear_inputs();
    #1 check_eq("run_idle_flush", 32'(bus_if.flush), 32'h0);
    tick();

    // exception beats mispredict
    bus_if.excp_i       = 1'b1;
    bus_if.excp_cause_i = 4'd2;
    bus_if.mem_valid_i  = 1'b1;
    bus_if.mispredict_i = 1'b1;
    bus_if.branch_tar_addr_real_i = 32'h3000_0040;
    #1;
    check_eq("excp_flush", 32'(bus_if.flush), 32'h1);
    check_eq("excp_pc", bus_if.new_pc, 32'h3000_0100);
    check_eq("excp_epc", bus_if.trap_epc, 32'h3000_0010);
    check_eq("excp_cause", bus_if.trap_cause, 32'h2);
    check_eq("excp_trap_we", 32'(bus_if.trap_we), 32'h1);
    tick();
    // mret is still honoured in HOLD
    bus_if.excp_i = 1'b0;
    bus_if.mret_i = 1'b1;
    #1;
    check_eq("hold_mret_flush", 32'(bus_if.flush), 32'h1);
    check_eq("hold_mret_pc", bus_if.new_pc, 32'h3000_0200);
    check_eq("hold_mret_trap_we", 32'(bus_if.trap_we), 32'h0);
    check_eq("hold_mret_epc", bus_if.trap_epc, 32'h0);
    tick();
    clear_inputs();
    tick();

    // interrupt held off by a MEM stall, taken when the stall drops
    bus_if.irq_i        = 1'b1;
    bus_if.irq_en_i     = 1'b1;
    bus_if.stallreq_mem = 1'b1;
    bus_if.mem_valid_i  = 1'b1;
    bus_if.mem_pc_i     = 32'h3000_0030;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("irq_wait_flush", 32'(bus_if.flush), 32'h0);
      tick();
    end
    check_eq("irq_pend_state", 32'(dut.r_state), 32'h2);
    bus_if.stallreq_mem = 1'b0;
    #1;
    check_eq("irq_flush", 32'(bus_if.flush), 32'h1);
    check_eq("irq_cause", bus_if.trap_cause, 32'h8000_000B);
    check_eq("irq_epc", bus_if.trap_epc, 32'h3000_0030);
    check_eq("irq_pc", bus_if.new_pc, 32'h3000_0100);
    tick();
    #1 check_eq("irq_hold_noflush", 32'(bus_if.flush), 32'h0);
    clear_inputs();
    repeat (3) tick();

    // timeout on the 4th consecutive MEM-stall cycle
    bus_if.stallreq_mem = 1'b1;
    bus_if.mem_valid_i  = 1'b1;
    bus_if.mem_pc_i     = 32'h3000_0020;
    for (int i = 1; i <= 4; i++) begin
      #1 check_eq("tmo_flush", 32'(bus_if.flush), (i == 4) ? 32'h1 : 32'h0);
      if (i < 4) tick();
    end
    check_eq("tmo_trap_we", 32'(bus_if.trap_we), 32'h1);
    check_eq("tmo_cause", bus_if.trap_cause, 32'h5);
    check_eq("tmo_epc", bus_if.trap_epc, 32'h3000_0020);
    check_eq("tmo_stall", 32'(bus_if.stall), 32'h0);
    tick();
    #1 check_eq("tmo_hold_stall", 32'(bus_if.stall), 32'h1F);
    clear_inputs();
    tick();

    // asynchronous reset while IRQ_PEND
    bus_if.irq_i    = 1'b1;
    bus_if.irq_en_i = 1'b1;
    repeat (3) tick();
    check_eq("pend_state", 32'(dut.r_state), 32'h2);
    bus_if.mispredict_i = 1'b1;
    bus_if.branch_tar_addr_real_i = 32'h3000_0080;
    #1 check_eq("pend_misp_pc", bus_if.new_pc, 32'h3000_0080);
    rst = 1'b0;
    #1;
    check_eq("arst_flush", 32'(bus_if.flush), 32'h0);
    check_eq("arst_new_pc", bus_if.new_pc, 32'h3000_0000);
    check_eq("arst_state", 32'(dut.r_state), 32'h0);
    check_eq("arst_trap_we", 32'(bus_if.trap_we), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    tick();
    bus_if.stallreq_ex = 1'b1;
    #1 check_eq("post_rst_stall", 32'(bus_if.stall), 32'h0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
